link_switch_ctrl: RTL and testbench
===================================

Name: link_switch_ctrl

Overview:
- Sequences the morse transceiver line switch. Drives its line_loop and line_invert controls and owns the morse_code_out drive.
- After start: runs a loopback self-test, then probes both line polarities for a remote carrier, then opens the data path between the local encoder/decoder and the line.
- Sits between the morse encoder/decoder and the transceiver switch.

Parameters:
- BIT_CYCLES, 16: clock cycles per self-test bit, and the carrier-detect high-run length. Legal range is ≥4.
- SETTLE_CYCLES, 4: wait after any switch reconfiguration before the line is used. Legal range is ≥1.
- TIMEOUT_CYCLES, 50000: carrier-search window per polarity. Also the auto-retry delay.
- TEST_PATTERN, 8'hA5: loopback self-test word, sent MSB first.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin link bring-up; single-cycle pulse
- stop  in  1  abort and return to IDLE; single-cycle pulse
- tx_data  in  1  morse bit from the encoder
- rx_data  out  1  received morse bit to the decoder
- line_loop  out  1  to the switch loop control
- line_invert  out  1  to the switch invert control
- morse_code_out  out  1  to the switch transmit input
- morse_code_in  in  1  from the switch receive output; asynchronous
- link_up  out  1  high in ACTIVE
- busy  out  1  high in LOOP_SETUP, LOOP_TEST, LINE_SETUP, LINE_WAIT
- fail_code  out  2  00 none, 01 loopback mismatch, 10 no carrier

Behaviour:
- Input sync: morse_code_in passes through a 2-FF synchronizer; all decisions use the synchronized bit rx_s.
- Reset: state=IDLE. All outputs are 0, fail_code=00, and all counters are 0.
- IDLE: loop=0, invert=0, morse_code_out=0, rx_data=0. start leads to LOOP_SETUP and clears fail_code.
- LOOP_SETUP: loop=1, invert=0, morse_code_out=0. Count SETTLE_CYCLES cycles, then go to LOOP_TEST.
- LOOP_TEST:
  - Loop stays 1. Drive TEST_PATTERN bit i (i=7..0), each held for BIT_CYCLES cycles.
  - Compare rx_s with the driven bit on the last cycle of each bit period.
  - On a mismatch, go to FAIL next cycle with fail_code=01.
  - After bit 0 matches, go to LINE_SETUP with invert=0.
  - Total duration is exactly 8*BIT_CYCLES cycles.
- LINE_SETUP: loop=0, morse_code_out=0. Hold invert at its current value for SETTLE_CYCLES cycles, then go to LINE_WAIT.
- LINE_WAIT:
  - Count consecutive cycles with rx_s=1; any 0 resets the run count. A run of BIT_CYCLES leads to ACTIVE.
  - Separately count cycles in this state. On reaching TIMEOUT_CYCLES:
    - if invert=0: set invert=1, go to LINE_SETUP;
    - if invert=1: go to FAIL with fail_code=10.
  - If carrier and timeout occur in the same cycle, carrier wins.
- ACTIVE: link_up=1, morse_code_out=tx_data (combinational pass), rx_data=rx_s. loop=0. invert is held at the probed value.
- FAIL:
  - Outputs are as in IDLE except that fail_code holds its value.
  - start leads to LOOP_SETUP: fail_code cleared, invert reset to 0.
- stop in any state leads to IDLE next cycle, with all outputs as in reset. stop has priority over start in the same cycle.
- start is ignored outside IDLE/FAIL. rst mid-operation behaves exactly as a reset.
- Counters are sized $clog2(max+1) and reset on every state entry. The self-test bit index is 3 bits and counts down from 7 to 0.
- The switch must never see loop=1 while morse_code_out carries tx_data: loop is 0 in ACTIVE.

Optional Feature:
- Macro: LINK_SWITCH_CTRL_AUTO_RETRY_EN.
- Defined: in FAIL, a counter runs for TIMEOUT_CYCLES cycles, then the block re-enters LOOP_SETUP automatically. fail_code is cleared on re-entry. start still retries immediately, and stop still goes to IDLE.
- Not defined: FAIL is held until start, stop or rst. No retry counter is synthesized.

Test Plan (bench params BIT_CYCLES=4, SETTLE_CYCLES=2, TIMEOUT_CYCLES=100, TEST_PATTERN=8'hA5; behavioural switch model in loop):
- Good path: start; model raises the remote line 40 cycles after LINE_WAIT entry with invert=0 → morse_code_out shows 1010_0101 at 4 cycles/bit; link_up=1 with invert=0; ACTIVE echoes tx_data on morse_code_out.
- Swapped line: remote carrier only on the inverted path → first LINE_WAIT times out after 100 cycles; invert becomes 1; link_up=1 with invert=1.
- No carrier: remote stays low → after two 100-cycle windows, state is FAIL, fail_code=10, busy=0, link_up=0.
- Broken loopback: model forces morse_code_in=0 → FAIL with fail_code=01 at the end of bit 7's period, 4 cycles into LOOP_TEST.
- Glitchy carrier: remote high for 3 cycles, low 1, then high 4 → only the 4-cycle run gives ACTIVE; stop and start in the same cycle give IDLE.
- With LINK_SWITCH_CTRL_AUTO_RETRY_EN defined: after fail_code=01, the block re-enters LOOP_SETUP 100 cycles later without start. Without the macro it stays in FAIL for ≥1000 cycles.

Source files
------------

// File: rtl/link_switch_ctrl.sv
// link_switch_ctrl: brings up the morse transceiver line switch.
// Sequence: loopback self-test, carrier probe on both line polarities, then
// opens the data path between the local encoder/decoder and the line.
// Optional build macro LINK_SWITCH_CTRL_AUTO_RETRY_EN: when defined, FAIL
// re-enters LOOP_SETUP by itself after TIMEOUT_CYCLES cycles.
module link_switch_ctrl #(
    parameter int         BIT_CYCLES     = 16,
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] TEST_PATTERN   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       tx_data,
    output logic       rx_data,
    output logic       line_loop,
    output logic       line_invert,
    output logic       morse_code_out,
    input  logic       morse_code_in,
    output logic       link_up,
    output logic       busy,
    output logic [1:0] fail_code
);

    // One shared cycle counter serves settle, bit-period, timeout and retry.
    localparam int MAX_BS  = (BIT_CYCLES > SETTLE_CYCLES) ? BIT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_BS) ? TIMEOUT_CYCLES : MAX_BS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(BIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOOP_SETUP, LOOP_TEST, LINE_SETUP, LINE_WAIT, ACTIVE, FAIL
    } state_t;

    typedef enum logic [1:0] {
        FAIL_NONE       = 2'b00,
        FAIL_LOOPBACK   = 2'b01,
        FAIL_NO_CARRIER = 2'b10
    } fail_t;

    state_t            state_q, state_d;
    fail_t             fail_q, fail_d;
    logic              invert_q, invert_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              rx_meta, rx_s;

    // Two-flop synchronizer for the asynchronous receive line.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let rx_meta -> rx_s form a real two-stage chain.
        if (rst) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= morse_code_in;
            rx_s    <= rx_meta;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fail_q    <= FAIL_NONE;
            invert_q  <= 1'b0;
            cnt_q     <= '0;
            run_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            fail_q    <= fail_d;
            invert_q  <= invert_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Next-state, counter updates and Moore outputs of the bring-up sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d        = state_q;
        fail_d         = fail_q;
        invert_d       = invert_q;
        cnt_d          = '0;
        run_d          = '0;
        bit_idx_d      = bit_idx_q;
        line_loop      = 1'b0;
        line_invert    = 1'b0;
        morse_code_out = 1'b0;
        rx_data        = 1'b0;
        link_up        = 1'b0;
        busy           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOOP_SETUP;
                    fail_d   = FAIL_NONE;
                    invert_d = 1'b0;
                end
            end

            LOOP_SETUP: begin
                line_loop = 1'b1;
                busy      = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) state_d = LOOP_TEST;
            end

            LOOP_TEST: begin
                line_loop      = 1'b1;
                busy           = 1'b1;
                morse_code_out = TEST_PATTERN[bit_idx_q];
                cnt_d          = cnt_q + 1'b1;
                // Judge each bit on the last cycle of its period, after the sync delay.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s != TEST_PATTERN[bit_idx_q]) begin
                        state_d = FAIL;
                        fail_d  = FAIL_LOOPBACK;
                    end else if (bit_idx_q == 3'd0) begin
                        state_d  = LINE_SETUP;
                        invert_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end
            end

            LINE_SETUP: begin
                busy        = 1'b1;
                line_invert = invert_q;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) state_d = LINE_WAIT;
            end

            LINE_WAIT: begin
                busy        = 1'b1;
                line_invert = invert_q;
                cnt_d       = cnt_q + 1'b1;
                run_d       = rx_s ? run_q + 1'b1 : '0;
                // Carrier is tested first so it wins over a coincident timeout.
                if (rx_s && run_q == RUN_LAST) begin
                    state_d = ACTIVE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (!invert_q) begin
                        invert_d = 1'b1;
                        state_d  = LINE_SETUP;
                    end else begin
                        state_d = FAIL;
                        fail_d  = FAIL_NO_CARRIER;
                    end
                end
            end

            ACTIVE: begin
                link_up        = 1'b1;
                line_invert    = invert_q;
                morse_code_out = tx_data;
                rx_data        = rx_s;
            end

            FAIL: begin
                if (start) begin
                    state_d  = LOOP_SETUP;
                    fail_d   = FAIL_NONE;
                    invert_d = 1'b0;
                end
`ifdef LINK_SWITCH_CTRL_AUTO_RETRY_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d  = LOOP_SETUP;
                        fail_d   = FAIL_NONE;
                        invert_d = 1'b0;
                    end
                end
`else
                // Held here until start, stop or rst.
`endif
            end

            default: state_d = IDLE;
        endcase

        // stop overrides everything, including a simultaneous start.
        if (stop) begin
            state_d  = IDLE;
            fail_d   = FAIL_NONE;
            invert_d = 1'b0;
        end

        // Counters restart on every state entry; the bit index starts at the MSB.
        if (state_d != state_q) begin
            cnt_d     = '0;
            run_d     = '0;
            bit_idx_d = (state_d == LOOP_TEST) ? 3'd7 : 3'd0;
        end
    end

    assign fail_code = fail_q;

endmodule

// File: tb/tb_link_switch_ctrl.sv
// Directed bench for link_switch_ctrl with a behavioural line-switch model:
// loop=1 feeds morse_code_out back (unless broken); loop=0 delivers the remote
// level only when line_invert matches the polarity the carrier is wired on.
module tb_link_switch_ctrl;

    localparam int         BIT_CYCLES     = 4;
    localparam int         SETTLE_CYCLES  = 2;
    localparam int         TIMEOUT_CYCLES = 100;
    localparam logic [7:0] TEST_PATTERN   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, start, stop, tx_data;
    logic       rx_data, line_loop, line_invert, morse_code_out, morse_code_in;
    logic       link_up, busy;
    logic [1:0] fail_code;

    logic remote, carrier_inv, broken;
    int   checks = 0;
    int   errors = 0;
    int   t      = 0;

    always #5 clk = ~clk;

    assign morse_code_in = line_loop ? (broken ? 1'b0 : morse_code_out)
                                     : ((line_invert == carrier_inv) ? remote : 1'b0);

    link_switch_ctrl #(
        .BIT_CYCLES    (BIT_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TEST_PATTERN  (TEST_PATTERN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .line_loop     (line_loop),
        .line_invert   (line_invert),
        .morse_code_out(morse_code_out),
        .morse_code_in (morse_code_in),
        .link_up       (link_up),
        .busy          (busy),
        .fail_code     (fail_code)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // t counts negedges since the posedge that accepted the last start pulse.
    task automatic step_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        t++;
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tx_data = 1'b0;
        remote = 1'b0; carrier_inv = 1'b0; broken = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_loop",    line_loop,      1'b0);
        check("reset_invert",  line_invert,    1'b0);
        check("reset_mco",     morse_code_out, 1'b0);
        check("reset_busy",    busy,           1'b0);
        check("reset_link_up", link_up,        1'b0);
        check("reset_rx_data", rx_data,        1'b0);
        check("reset_fail",    fail_code,      2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Good path: LOOP_SETUP t=0..1, LOOP_TEST t=2..33, LINE_SETUP t=34..35, LINE_WAIT from t=36.
        start_run();
        check("setup_loop", line_loop,      1'b1);
        check("setup_busy", busy,           1'b1);
        check("setup_mco",  morse_code_out, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step_to(3 + 4 * k);
            check($sformatf("pattern_bit%0d", 7 - k), morse_code_out, TEST_PATTERN[7 - k]);
        end
        step_to(35);
        check("line_setup_loop", line_loop, 1'b0);
        check("line_setup_busy", busy,      1'b1);
        // A start pulse in LINE_WAIT must not disturb the sequence.
        step_to(50);
        start = 1'b1;
        @(negedge clk);
        t++;
        start = 1'b0;
        step_to(76);
        remote = 1'b1;
        // rx_s high from t=78; the run of 4 completes at t=81, ACTIVE visible at t=82.
        step_to(81);
        check("good_pre_active", link_up, 1'b0);
        step_to(82);
        check("good_link_up", link_up,     1'b1);
        check("good_invert",  line_invert, 1'b0);
        check("good_busy",    busy,        1'b0);
        check("good_loop",    line_loop,   1'b0);
        check("good_rx_data", rx_data,     1'b1);
        tx_data = 1'b1; #1;
        check("echo_tx1", morse_code_out, 1'b1);
        tx_data = 1'b0; #1;
        check("echo_tx0", morse_code_out, 1'b0);
        tx_data = 1'b1;
        pulse_stop();
        check("stop_link_up", link_up,        1'b0);
        check("stop_mco",     morse_code_out, 1'b0);
        tx_data = 1'b0;

        // Swapped line: carrier only reachable with invert=1.
        carrier_inv = 1'b1;
        start_run();
        step_to(135);
        check("swap_first_invert", line_invert, 1'b0);
        check("swap_first_busy",   busy,        1'b1);
        step_to(136);
        check("swap_invert_set", line_invert, 1'b1);
        check("swap_setup_busy", busy,        1'b1);
        step_to(141);
        check("swap_pre_active", link_up, 1'b0);
        step_to(142);
        check("swap_link_up", link_up,     1'b1);
        check("swap_invert",  line_invert, 1'b1);
        pulse_stop();
        check("swap_stop_invert", line_invert, 1'b0);

        // No carrier: two 100-cycle windows, FAIL visible at t=238.
        remote = 1'b0;
        start_run();
        step_to(237);
        check("nocar_busy_last",   busy,        1'b1);
        check("nocar_invert_last", line_invert, 1'b1);
        check("nocar_fail_last",   fail_code,   2'b00);
        step_to(238);
        check("nocar_fail",    fail_code,   2'b10);
        check("nocar_busy",    busy,        1'b0);
        check("nocar_link_up", link_up,     1'b0);
        check("nocar_invert",  line_invert, 1'b0);

        // Broken loopback, started from FAIL: mismatch judged at t=5, FAIL at t=6.
        broken = 1'b1;
        start_run();
        check("broken_fail_cleared", fail_code, 2'b00);
        step_to(5);
        check("broken_busy_bit7", busy,      1'b1);
        check("broken_loop_bit7", line_loop, 1'b1);
        step_to(6);
        check("broken_fail", fail_code, 2'b01);
        check("broken_busy", busy,      1'b0);
        check("broken_loop", line_loop, 1'b0);
`ifdef LINK_SWITCH_CTRL_AUTO_RETRY_EN
        step_to(105);
        check("retry_wait_busy", busy,      1'b0);
        check("retry_wait_fail", fail_code, 2'b01);
        step_to(106);
        check("retry_busy", busy,      1'b1);
        check("retry_loop", line_loop, 1'b1);
        check("retry_fail", fail_code, 2'b00);
`else
        step_to(1006);
        check("hold_fail", fail_code, 2'b01);
        check("hold_busy", busy,      1'b0);
        check("hold_loop", line_loop, 1'b0);
`endif
        pulse_stop();
        check("stop_clears_fail", fail_code, 2'b00);
        check("stop_idle_busy",   busy,      1'b0);
        broken = 1'b0;

        // Glitchy carrier: rx_s high t=52..54, low t=55, high from t=56; ACTIVE at t=60.
        carrier_inv = 1'b0;
        start_run();
        step_to(50);
        remote = 1'b1;
        step_to(53);
        remote = 1'b0;
        step_to(54);
        remote = 1'b1;
        step_to(56);
        check("glitch_short_run", link_up, 1'b0);
        step_to(59);
        check("glitch_pre_active", link_up, 1'b0);
        step_to(60);
        check("glitch_link_up", link_up, 1'b1);
        // stop wins over a simultaneous start.
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        t++;
        stop = 1'b0; start = 1'b0;
        check("stop_start_link_up", link_up,   1'b0);
        check("stop_start_busy",    busy,      1'b0);
        check("stop_start_loop",    line_loop, 1'b0);

        // rst in the middle of the self-test.
        remote = 1'b0;
        start_run();
        step_to(10);
        check("midrst_pre_loop", line_loop, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_loop", line_loop,      1'b0);
        check("midrst_busy", busy,           1'b0);
        check("midrst_mco",  morse_code_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
